phimap_trig_sched: RTL and testbench
====================================

Name: phimap_trig_sched

Overview:
- Sequencer for the trigonometric functional-link expansion Phi(x) = [x, sin(k·pi·x), cos(k·pi·x), k = 1..(Q_ORD-1)/2].
- Drives one shared sin/cos core through a request/grant/done handshake, one harmonic at a time, instead of instantiating one core per harmonic.
- Computes each harmonic angle, collects the results into a packed expansion vector, and hands that vector to the adaptive-filter datapath with a valid/ready handshake.

Parameters:
- Q_ORD, 7, expansion order (odd). Harmonic count K = (Q_ORD-1)/2.
- WIDTH, 16, sample and output word width.
- QP, 12, fractional bits of x_in and of theta.
- TIMEOUT, 64, maximum cycles in WAIT before the harmonic is abandoned.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset. One clock domain; reset is synchronous and active-high.
- x_in, input, WIDTH, signed input sample, Q(WIDTH-QP).QP.
- x_valid, input, 1, x_in is valid.
- x_ready, output, 1, block can accept a sample.
- theta_out, output, WIDTH+1, signed angle to the shared trig core, Q4.12.
- trig_req, output, 1, request for the shared trig core.
- trig_gnt, input, 1, grant from the trig core or its arbiter.
- trig_done, input, 1, trig_sin and trig_cos are valid.
- trig_sin, input, WIDTH, signed sine result, Q1.15.
- trig_cos, input, WIDTH, signed cosine result, Q1.15.
- phi_out, output, Q_ORD*WIDTH, packed expansion; slot j is bits [WIDTH*j +: WIDTH].
- phi_valid, output, 1, phi_out is valid.
- phi_ready, input, 1, consumer accepts phi_out.
- busy, output, 1, state is not IDLE.
- timeout_err, output, 1, sticky flag: at least one harmonic has timed out.

Behaviour:
- Reset: state = IDLE, k = 1, all slot registers = 0, timeout counter = 0.
  - Output values in reset: x_ready=1, trig_req=0, phi_valid=0, busy=0, timeout_err=0, theta_out=0, phi_out=0.
  - Reset in any state aborts the operation in progress immediately. No partial result is ever presented.
- IDLE: x_ready=1.
  - When x_valid=1, latch x_in into slot 0 and into the x register, set k=1, go to ISSUE.
- ISSUE: trig_req=1, theta_out = theta(k), held stable.
  - When trig_gnt=1 in the same cycle, go to WAIT and clear the timeout counter.
  - Otherwise stay in ISSUE with no time limit.
- WAIT: trig_req=0; the timeout counter increments each cycle.
  - On trig_done=1: slot 2k-1 = trig_sin >>> 3 and slot 2k = trig_cos >>> 3 (arithmetic shift).
  - On trig_done=1 with k=K, go to OUT; otherwise set k=k+1 and go to ISSUE.
  - If the counter reaches TIMEOUT-1 with trig_done=0: write 0 to both slots, set timeout_err, and advance exactly as on done.
  - trig_done in any state other than WAIT is ignored.
- OUT: phi_valid=1; phi_out is held stable until phi_ready=1.
  - On phi_ready=1, go to IDLE. x_ready becomes 1 in the following cycle; no back-to-back acceptance in OUT.
- Angle arithmetic for harmonic k:
  - C_k = k·0x3244 (pi in Q4.12), exact integer multiple, so C_2 = 0x6488 and C_3 = 0x96CC.
  - Full product: P = C_k · x, signed, 2·WIDTH+1 bits.
  - Round: R = P + 2^(QP-1).
  - theta(k) = R[QP +: WIDTH+1]. Truncate; no saturation.
- Latency with trig_gnt=1 at ISSUE and trig_done 2 cycles after the grant cycle:
  - 3 cycles per harmonic.
  - Sample accepted at cycle t0 gives phi_valid at t0 + 1 + 3K (t0+10 for K=3).
- busy = (state != IDLE). timeout_err is cleared only by rst.

Test Plan:
- rst held 3 cycles, then released → x_ready=1, every other output 0.
- x_in=0x1000, gnt tied to 1, done 2 cycles after each grant, model returns sin=0x4000 and cos=0x2000:
  - theta_out sequence is 0x03244, 0x06488, 0x096CC.
  - phi_valid at t0+10 with slot0=0x1000, odd slots 0x0800, even slots 0x0400.
- x_in=0xF000 (-1.0): theta_out first value is 0x1CDBC. Model sin=0xC000 gives slot1=0xF800, confirming sign extension on the shift.
- trig_gnt withheld 5 cycles on harmonic 2 → trig_req and theta_out=0x06488 stay stable for all 5 cycles; final vector is correct.
- trig_done never returns on harmonic 1 with TIMEOUT=8 → after 8 WAIT cycles, slots 1 and 2 = 0 and timeout_err=1. Harmonics 2 and 3 then complete normally. A spurious trig_done asserted in ISSUE is ignored.
- phi_ready low for 4 cycles → phi_out stable and x_ready=0 throughout. rst pulsed in the middle of WAIT → IDLE on the next cycle with all slots 0.

Source files
------------

// File: rtl/phimap_trig_sched.sv
// Sequencer for the trigonometric functional-link expansion: time-shares one sin/cos
// core across the K harmonics and packs [x, sin(k*pi*x), cos(k*pi*x)] into phi_out.
module phimap_trig_sched #(
    parameter int Q_ORD   = 7,
    parameter int WIDTH   = 16,
    parameter int QP      = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic                      x_valid,
    output logic                      x_ready,
    output logic        [WIDTH:0]     theta_out,
    output logic                      trig_req,
    input  logic                      trig_gnt,
    input  logic                      trig_done,
    input  logic signed [WIDTH-1:0]   trig_sin,
    input  logic signed [WIDTH-1:0]   trig_cos,
    output logic [Q_ORD*WIDTH-1:0]    phi_out,
    output logic                      phi_valid,
    input  logic                      phi_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready (or
    // trig_req and trig_gnt) are both high; valid/req and their payload stay
    // stable until that edge, and ready never depends on valid.

    localparam int K        = (Q_ORD - 1) / 2;
    localparam int KW       = $clog2(K + 1);
    localparam int CW       = $clog2(TIMEOUT) + 1;
    localparam int PI_Q4_12 = 'h3244;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [KW-1:0]           r_k;
    logic [CW-1:0]           r_cnt;
    logic signed [WIDTH-1:0] r_x;
    logic [WIDTH-1:0]        r_slot [Q_ORD];
    logic                    r_err;

    logic signed [WIDTH:0]   w_ck;
    logic signed [2*WIDTH:0] w_prod;
    logic [2*WIDTH:0]        w_rnd;
    logic [WIDTH:0]          w_theta;
    logic signed [WIDTH-1:0] w_sin_sh;
    logic signed [WIDTH-1:0] w_cos_sh;
    logic                    w_timeout;
    logic                    w_last;
    logic                    w_advance;

    // theta(k) = round(k*pi*x) in Q4.12; the product is exact, the result wraps.
    assign w_ck     = (WIDTH+1)'(int'(r_k) * PI_Q4_12);
    assign w_prod   = $signed({{WIDTH{w_ck[WIDTH]}}, w_ck})
                    * $signed({{(WIDTH+1){r_x[WIDTH-1]}}, r_x});
    assign w_rnd    = w_prod + (2*WIDTH+1)'(1 << (QP - 1));
    assign w_theta  = (WIDTH+1)'(w_rnd >> QP);

    assign w_sin_sh  = trig_sin >>> 3;
    assign w_cos_sh  = trig_cos >>> 3;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1)) && !trig_done;
    assign w_last    = (r_k == KW'(K));
    assign w_advance = trig_done || w_timeout;

    always_comb begin
        w_next    = r_state;
        x_ready   = 1'b0;
        trig_req  = 1'b0;
        phi_valid = 1'b0;
        theta_out = '0;
        case (r_state)
            S_IDLE: begin
                x_ready = 1'b1;
                if (x_valid) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                trig_req  = 1'b1;
                theta_out = w_theta;
                if (trig_gnt) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_advance) w_next = w_last ? S_OUT : S_ISSUE;
            end
            S_OUT: begin
                phi_valid = 1'b1;
                if (phi_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= KW'(1);
            r_cnt   <= '0;
            r_x     <= '0;
            r_err   <= 1'b0;
            for (int j = 0; j < Q_ORD; j++) r_slot[j] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (x_valid) begin
                        r_x       <= x_in;
                        r_slot[0] <= x_in;
                        r_k       <= KW'(1);
                    end
                end
                S_ISSUE: begin
                    if (trig_gnt) r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A timed-out harmonic contributes zeros rather than stale data.
                    for (int j = 1; j < Q_ORD; j++) begin
                        if (w_advance && (2 * int'(r_k) - 1 == j))
                            r_slot[j] <= trig_done ? w_sin_sh : '0;
                        if (w_advance && (2 * int'(r_k) == j))
                            r_slot[j] <= trig_done ? w_cos_sh : '0;
                    end
                    if (w_timeout) r_err <= 1'b1;
                    if (w_advance && !w_last) r_k <= r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        phi_out = '0;
        for (int j = 0; j < Q_ORD; j++) phi_out[WIDTH*j +: WIDTH] = r_slot[j];
    end

    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_phimap_trig_sched.sv
// Bench for phimap_trig_sched: scripted trig-core responder, arithmetic angle model
// and an expected-vector queue for the packed expansion.
module tb_phimap_trig_sched;

    localparam int Q_ORD   = 7;
    localparam int WIDTH   = 16;
    localparam int QP      = 12;
    localparam int TIMEOUT = 8;
    localparam int K       = (Q_ORD - 1) / 2;
    localparam int PW      = Q_ORD * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] x_in;
    logic             x_valid;
    logic             x_ready;
    logic [WIDTH:0]   theta_out;
    logic             trig_req;
    logic             trig_gnt;
    logic             trig_done;
    logic [WIDTH-1:0] trig_sin;
    logic [WIDTH-1:0] trig_cos;
    logic [PW-1:0]    phi_out;
    logic             phi_valid;
    logic             phi_ready;
    logic             busy;
    logic             timeout_err;
    logic [1:0]       dbg_state;

    phimap_trig_sched #(.Q_ORD(Q_ORD), .WIDTH(WIDTH), .QP(QP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .theta_out(theta_out), .trig_req(trig_req), .trig_gnt(trig_gnt),
        .trig_done(trig_done), .trig_sin(trig_sin), .trig_cos(trig_cos),
        .phi_out(phi_out), .phi_valid(phi_valid), .phi_ready(phi_ready),
        .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] exp_q[$];

    logic [WIDTH-1:0] sin_v [1:K];
    logic [WIDTH-1:0] cos_v [1:K];
    logic [WIDTH:0]   obs_theta [1:K];
    bit               obs_issue_ok;
    bit               obs_hold_ok;
    int               obs_lat;
    int               obs_wait;
    logic [PW-1:0]    obs_phi;

    // round(k * pi * x) in Q4.12, with pi = 12868 / 4096; wraps to 17 bits.
    function automatic logic [WIDTH:0] theta_model(int k, logic [WIDTH-1:0] x);
        longint xs, p;
        xs = longint'($signed(x));
        p  = longint'(k) * 12868 * xs + 2048;
        return (WIDTH+1)'(p >>> QP);
    endfunction

    function automatic logic [WIDTH-1:0] shr3(logic [WIDTH-1:0] v);
        int s;
        s = int'($signed(v));
        return WIDTH'(s >>> 3);
    endfunction

    function automatic logic [PW-1:0] build_vec(logic [WIDTH-1:0] x, int drop_k);
        logic [PW-1:0] v;
        v = '0;
        v[0 +: WIDTH] = x;
        for (int k = 1; k <= K; k++) begin
            if (k != drop_k) begin
                v[WIDTH*(2*k-1) +: WIDTH] = shr3(sin_v[k]);
                v[WIDTH*(2*k)   +: WIDTH] = shr3(cos_v[k]);
            end
        end
        return v;
    endfunction

    // Plays one sample through the block acting as trig core and consumer.
    task automatic drive_sample(input logic [WIDTH-1:0] x, input int hold_k, input int hold_n,
                                input int drop_k, input bit spurious, input int ready_n);
        int t0, n, guard;
        obs_issue_ok = 1'b1;
        obs_hold_ok  = 1'b1;
        obs_wait     = 0;
        obs_lat      = -1;
        x_in    = x;
        x_valid = 1'b1;
        t0      = cyc;
        @(negedge clk);
        x_valid = 1'b0;
        x_in    = WIDTH'($urandom);
        for (int k = 1; k <= K; k++) begin
            n = (k == hold_k) ? hold_n : 0;
            obs_theta[k] = theta_out;
            for (int h = 0; h < n; h++) begin
                if (trig_req !== 1'b1 || theta_out !== obs_theta[k]) obs_issue_ok = 1'b0;
                trig_gnt  = 1'b0;
                trig_done = spurious && (h == 0);
                trig_sin  = WIDTH'($urandom);
                trig_cos  = WIDTH'($urandom);
                @(negedge clk);
                trig_done = 1'b0;
            end
            if (trig_req !== 1'b1 || theta_out !== obs_theta[k]) obs_issue_ok = 1'b0;
            trig_gnt = 1'b1;
            @(negedge clk);
            trig_gnt = 1'b0;
            if (k == drop_k) begin
                guard = 0;
                while (busy === 1'b1 && trig_req !== 1'b1 && phi_valid !== 1'b1 && guard < 100) begin
                    guard++;
                    @(negedge clk);
                end
                obs_wait = guard;
            end else begin
                @(negedge clk);
                trig_done = 1'b1;
                trig_sin  = sin_v[k];
                trig_cos  = cos_v[k];
                @(negedge clk);
                trig_done = 1'b0;
            end
        end
        guard = 0;
        while (phi_valid !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (phi_valid === 1'b1) obs_lat = cyc - t0;
        obs_phi = phi_out;
        for (int r = 0; r < ready_n; r++) begin
            if (phi_out !== obs_phi || x_ready !== 1'b0 || phi_valid !== 1'b1) obs_hold_ok = 1'b0;
            phi_ready = 1'b0;
            @(negedge clk);
        end
        phi_ready = 1'b1;
        @(negedge clk);
        phi_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL reset_x_ready got=%b exp=1", x_ready); end
        total++; if (trig_req !== 1'b0) begin bad++; $display("FAIL reset_trig_req got=%b exp=0", trig_req); end
        total++; if (phi_valid !== 1'b0) begin bad++; $display("FAIL reset_phi_valid got=%b exp=0", phi_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        total++; if (theta_out !== '0) begin bad++; $display("FAIL reset_theta got=%h exp=0", theta_out); end
        total++; if (phi_out !== '0) begin bad++; $display("FAIL reset_phi_out got=%h exp=0", phi_out); end
    endtask

    task automatic test_basic;
        logic [PW-1:0] e;
        for (int k = 1; k <= K; k++) begin sin_v[k] = 16'h4000; cos_v[k] = 16'h2000; end
        exp_q.push_back(build_vec(16'h1000, 0));
        drive_sample(16'h1000, 0, 0, 0, 1'b0, 0);
        for (int k = 1; k <= K; k++) begin
            total++;
            if (obs_theta[k] !== theta_model(k, 16'h1000)) begin
                bad++; $display("FAIL basic_theta k=%0d got=%h exp=%h", k, obs_theta[k], theta_model(k, 16'h1000));
            end
        end
        total++; if (obs_lat !== 1 + 3*K) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", obs_lat, 1 + 3*K); end
        e = exp_q.pop_front();
        total++; if (obs_phi !== e) begin bad++; $display("FAIL basic_phi got=%h exp=%h", obs_phi, e); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL basic_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_negative;
        logic [PW-1:0] e;
        for (int k = 1; k <= K; k++) begin sin_v[k] = 16'hC000; cos_v[k] = WIDTH'($urandom); end
        exp_q.push_back(build_vec(16'hF000, 0));
        drive_sample(16'hF000, 0, 0, 0, 1'b0, 0);
        total++;
        if (obs_theta[1] !== theta_model(1, 16'hF000)) begin
            bad++; $display("FAIL neg_theta1 got=%h exp=%h", obs_theta[1], theta_model(1, 16'hF000));
        end
        e = exp_q.pop_front();
        total++; if (obs_phi !== e) begin bad++; $display("FAIL neg_phi got=%h exp=%h", obs_phi, e); end
    endtask

    task automatic test_gnt_hold;
        logic [PW-1:0] e;
        for (int k = 1; k <= K; k++) begin sin_v[k] = WIDTH'($urandom); cos_v[k] = WIDTH'($urandom); end
        exp_q.push_back(build_vec(16'h1000, 0));
        drive_sample(16'h1000, 2, 5, 0, 1'b0, 0);
        total++; if (obs_issue_ok !== 1'b1) begin bad++; $display("FAIL gnt_hold_stable got=%b exp=1", obs_issue_ok); end
        total++;
        if (obs_theta[2] !== theta_model(2, 16'h1000)) begin
            bad++; $display("FAIL gnt_hold_theta2 got=%h exp=%h", obs_theta[2], theta_model(2, 16'h1000));
        end
        e = exp_q.pop_front();
        total++; if (obs_phi !== e) begin bad++; $display("FAIL gnt_hold_phi got=%h exp=%h", obs_phi, e); end
    endtask

    task automatic test_ready_hold;
        logic [PW-1:0] e;
        logic [WIDTH-1:0] x;
        x = WIDTH'($urandom);
        for (int k = 1; k <= K; k++) begin sin_v[k] = WIDTH'($urandom); cos_v[k] = WIDTH'($urandom); end
        exp_q.push_back(build_vec(x, 0));
        drive_sample(x, 0, 0, 0, 1'b0, 4);
        total++; if (obs_hold_ok !== 1'b1) begin bad++; $display("FAIL ready_hold_stable got=%b exp=1", obs_hold_ok); end
        e = exp_q.pop_front();
        total++; if (obs_phi !== e) begin bad++; $display("FAIL ready_hold_phi got=%h exp=%h", obs_phi, e); end
        total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL ready_hold_xready_after got=%b exp=1", x_ready); end
    endtask

    task automatic test_random;
        logic [PW-1:0] e;
        logic [WIDTH-1:0] x;
        int hk, hn, rn;
        for (int it = 0; it < 12; it++) begin
            x  = WIDTH'($urandom);
            hk = $urandom_range(0, K);
            hn = $urandom_range(1, 4);
            rn = $urandom_range(0, 3);
            for (int k = 1; k <= K; k++) begin sin_v[k] = WIDTH'($urandom); cos_v[k] = WIDTH'($urandom); end
            exp_q.push_back(build_vec(x, 0));
            drive_sample(x, hk, hn, 0, 1'b0, rn);
            for (int k = 1; k <= K; k++) begin
                total++;
                if (obs_theta[k] !== theta_model(k, x)) begin
                    bad++; $display("FAIL rand_theta it=%0d k=%0d got=%h exp=%h", it, k, obs_theta[k], theta_model(k, x));
                end
            end
            e = exp_q.pop_front();
            total++; if (obs_phi !== e) begin bad++; $display("FAIL rand_phi it=%0d got=%h exp=%h", it, obs_phi, e); end
            total++;
            if (obs_lat !== 1 + 3*K + ((hk != 0) ? hn : 0)) begin
                bad++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, obs_lat, 1 + 3*K + ((hk != 0) ? hn : 0));
            end
            total++;
            if (obs_issue_ok !== 1'b1 || obs_hold_ok !== 1'b1) begin
                bad++; $display("FAIL rand_stable it=%0d got=%b%b exp=11", it, obs_issue_ok, obs_hold_ok);
            end
        end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rand_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_timeout;
        logic [PW-1:0] e;
        logic [WIDTH-1:0] x;
        x = WIDTH'($urandom);
        for (int k = 1; k <= K; k++) begin sin_v[k] = WIDTH'($urandom); cos_v[k] = WIDTH'($urandom); end
        exp_q.push_back(build_vec(x, 1));
        drive_sample(x, 2, 2, 1, 1'b1, 0);
        total++; if (obs_wait !== TIMEOUT) begin bad++; $display("FAIL timeout_wait_cycles got=%0d exp=%0d", obs_wait, TIMEOUT); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_flag got=%b exp=1", timeout_err); end
        e = exp_q.pop_front();
        total++; if (obs_phi !== e) begin bad++; $display("FAIL timeout_phi got=%h exp=%h", obs_phi, e); end
        total++;
        if (obs_lat !== 1 + 3*K + (TIMEOUT - 2) + 2) begin
            bad++; $display("FAIL timeout_latency got=%0d exp=%0d", obs_lat, 1 + 3*K + (TIMEOUT - 2) + 2);
        end
    endtask

    task automatic test_reset_mid;
        x_in    = 16'h1234;
        x_valid = 1'b1;
        @(negedge clk);
        x_valid  = 1'b0;
        trig_gnt = 1'b1;
        @(negedge clk);
        trig_gnt = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (phi_out !== '0) begin bad++; $display("FAIL rstmid_phi_out got=%h exp=0", phi_out); end
        total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL rstmid_x_ready got=%b exp=1", x_ready); end
        total++; if (phi_valid !== 1'b0) begin bad++; $display("FAIL rstmid_phi_valid got=%b exp=0", phi_valid); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rstmid_timeout_err got=%b exp=0", timeout_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        x_in      = '0;
        x_valid   = 1'b0;
        trig_gnt  = 1'b0;
        trig_done = 1'b0;
        trig_sin  = '0;
        trig_cos  = '0;
        phi_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_gnt_hold();
        test_ready_hold();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
